// File: rtl/cbfp_index_scheduler_if.sv
// Handshake/bus bundle between the CBFP index producers, the butterfly pipeline and cbfp_stage2.
interface cbfp_index_scheduler_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 5
);
    logic [N-1:0][IDX_W-1:0] idx0_in;
    logic                    idx0_valid;
    logic [N-1:0][IDX_W-1:0] idx1_in;
    logic                    idx1_valid;
    logic                    data_req;
    logic [N-1:0][IDX_W-1:0] idx0_out;
    logic [N-1:0][IDX_W-1:0] idx1_out;
    logic                    idx_valid;
    logic                    frame_start;
    logic                    frame_done;
    logic                    busy;

    modport master (
        output idx0_in, idx0_valid, idx1_in, idx1_valid, data_req,
        input  idx0_out, idx1_out, idx_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  idx0_in, idx0_valid, idx1_in, idx1_valid, data_req,
        output idx0_out, idx1_out, idx_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/cbfp_index_scheduler.sv
// Buffers stage-0/stage-1 CBFP exponent vectors and releases them in lockstep with butterfly22 output,
// framing blocks into FFT frames. Define FFT_IDX_SCHED_STATUS_EN to add occupancy/error/count status ports.
module cbfp_index_scheduler #(
    parameter int unsigned N          = 16,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned FRAME_BLKS = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    cbfp_index_scheduler_if.slave         bus
`ifdef FFT_IDX_SCHED_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]        lvl0,
    output logic [$clog2(DEPTH):0]        lvl1,
    output logic                          ovf_err,
    output logic                          udf_err,
    output logic [$clog2(FRAME_BLKS):0]   blk_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(FRAME_BLKS) + 1;
    localparam logic [AW:0] PTR_MSB = (AW+1)'(1) << AW;

    typedef logic [N-1:0][IDX_W-1:0] vec_t;
    typedef enum logic {IDLE, RUN} state_t;

    vec_t        mem0_q [DEPTH];
    vec_t        mem0_d [DEPTH];
    vec_t        mem1_q [DEPTH];
    vec_t        mem1_d [DEPTH];
    logic [AW:0] wp0_q, wp0_d, rp0_q, rp0_d;
    logic [AW:0] wp1_q, wp1_d, rp1_q, rp1_d;

    vec_t        idx0_out_q, idx0_out_d;
    vec_t        idx1_out_q, idx1_out_d;
    logic        idx_valid_q, idx_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    state_t      state_q, state_d;
    logic [CW-1:0] blk_cnt_q, blk_cnt_d;

    logic empty0, empty1, full0, full1;
    logic pop, push0, push1, drop, udf;

    assign empty0 = (wp0_q == rp0_q);
    assign empty1 = (wp1_q == rp1_q);
    assign full0  = ((wp0_q ^ rp0_q) == PTR_MSB);
    assign full1  = ((wp1_q ^ rp1_q) == PTR_MSB);

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is accepted alongside it.
    // No bypass: an empty FIFO never pops, even with a same-cycle push.
    assign pop   = bus.data_req && !empty0 && !empty1;
    assign push0 = bus.idx0_valid && (!full0 || pop);
    assign push1 = bus.idx1_valid && (!full1 || pop);
    assign drop  = (bus.idx0_valid && full0 && !pop) || (bus.idx1_valid && full1 && !pop);
    assign udf   = bus.data_req && !pop;

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        wp0_d  = wp0_q;
        wp1_d  = wp1_q;
        rp0_d  = rp0_q;
        rp1_d  = rp1_q;
        if (push0) begin
            mem0_d[wp0_q[AW-1:0]] = bus.idx0_in;
            wp0_d = wp0_q + 1'b1;
        end
        if (push1) begin
            mem1_d[wp1_q[AW-1:0]] = bus.idx1_in;
            wp1_d = wp1_q + 1'b1;
        end
        if (pop) begin
            rp0_d = rp0_q + 1'b1;
            rp1_d = rp1_q + 1'b1;
        end
    end

    always_comb begin
        idx0_out_d    = idx0_out_q;
        idx1_out_d    = idx1_out_q;
        idx_valid_d   = pop;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        state_d       = state_q;
        blk_cnt_d     = blk_cnt_q;
        if (pop) begin
            idx0_out_d = mem0_q[rp0_q[AW-1:0]];
            idx1_out_d = mem1_q[rp1_q[AW-1:0]];
            case (state_q)
                IDLE: begin
                    frame_start_d = 1'b1;
                    if (FRAME_BLKS == 1) begin
                        frame_done_d = 1'b1;
                        blk_cnt_d    = '0;
                    end else begin
                        state_d   = RUN;
                        blk_cnt_d = CW'(1);
                    end
                end
                RUN: begin
                    if (blk_cnt_q == CW'(FRAME_BLKS - 1)) begin
                        state_d      = IDLE;
                        blk_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (udf) begin
            idx0_out_d = '0;
            idx1_out_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem0_q <= mem0_d;
        mem1_q <= mem1_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp0_q         <= '0;
            rp0_q         <= '0;
            wp1_q         <= '0;
            rp1_q         <= '0;
            idx0_out_q    <= '0;
            idx1_out_q    <= '0;
            idx_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            state_q       <= IDLE;
            blk_cnt_q     <= '0;
        end else begin
            wp0_q         <= wp0_d;
            rp0_q         <= rp0_d;
            wp1_q         <= wp1_d;
            rp1_q         <= rp1_d;
            idx0_out_q    <= idx0_out_d;
            idx1_out_q    <= idx1_out_d;
            idx_valid_q   <= idx_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
        end
    end

    assign bus.idx0_out    = idx0_out_q;
    assign bus.idx1_out    = idx1_out_q;
    assign bus.idx_valid   = idx_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = (state_q == RUN);

`ifdef FFT_IDX_SCHED_STATUS_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;

    always_comb begin
        ovf_err_d = ovf_err_q | drop;
        udf_err_d = udf_err_q | udf;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign lvl0      = wp0_q - rp0_q;
    assign lvl1      = wp1_q - rp1_q;
    assign ovf_err   = ovf_err_q;
    assign udf_err   = udf_err_q;
    assign blk_cnt_o = blk_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_cbfp_index_scheduler.sv
// Directed self-checking bench for cbfp_index_scheduler (status ports checked when FFT_IDX_SCHED_STATUS_EN is defined).
module tb_cbfp_index_scheduler;
    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 5;

    typedef logic [N-1:0][IDX_W-1:0] vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    vec_t q0[$];
    vec_t q1[$];
    vec_t e0, e1;

    always #5 clk = ~clk;

    cbfp_index_scheduler_if #(.N(N), .IDX_W(IDX_W)) bus ();

`ifdef FFT_IDX_SCHED_STATUS_EN
    logic [5:0] lvl0, lvl1;
    logic       ovf_err, udf_err;
    logic [5:0] blk_cnt_o;
`endif

    cbfp_index_scheduler #(.N(N), .IDX_W(IDX_W), .DEPTH(32), .FRAME_BLKS(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef FFT_IDX_SCHED_STATUS_EN
        ,
        .lvl0      (lvl0),
        .lvl1      (lvl1),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err),
        .blk_cnt_o (blk_cnt_o)
`endif
    );

    function automatic vec_t vec(input int unsigned k);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = IDX_W'(k);
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn           = 1'b0;
        bus.idx0_in    = '0;
        bus.idx1_in    = '0;
        bus.idx0_valid = 1'b0;
        bus.idx1_valid = 1'b0;
        bus.data_req   = 1'b0;
        repeat (3) step();
        check("rst_valid", bus.idx_valid, 1'b0);
        check("rst_out0", bus.idx0_out, '0);
        check("rst_out1", bus.idx1_out, '0);
        check("rst_fs", bus.frame_start, 1'b0);
        check("rst_fd", bus.frame_done, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rstn = 1'b1;
        step();

        // Test 1: 32 vectors on both sources, then 32 isolated requests
        for (int k = 0; k < 32; k++) begin
            bus.idx0_in = vec(k); bus.idx1_in = vec(k);
            bus.idx0_valid = 1'b1; bus.idx1_valid = 1'b1;
            step();
        end
        bus.idx0_valid = 1'b0; bus.idx1_valid = 1'b0;
`ifdef FFT_IDX_SCHED_STATUS_EN
        check("t1_lvl0", lvl0, 6'd32);
`endif
        for (int k = 0; k < 32; k++) begin
            bus.data_req = 1'b1;
            step();
            check("t1_valid", bus.idx_valid, 1'b1);
            check("t1_out0", bus.idx0_out, vec(k));
            check("t1_out1", bus.idx1_out, vec(k));
            check("t1_fs", bus.frame_start, logic'(k == 0));
            check("t1_fd", bus.frame_done, logic'(k == 31));
            check("t1_busy", bus.busy, logic'(k != 31));
            bus.data_req = 1'b0;
            step();
            check("t1_gap", bus.idx_valid, 1'b0);
            check("t1_hold", bus.idx0_out, vec(k));
        end

        // Test 2: 33 pushes on idx0, the last one dropped
        for (int k = 0; k < 33; k++) begin
            bus.idx0_in = vec(k); bus.idx0_valid = 1'b1;
            step();
        end
        bus.idx0_valid = 1'b0;
`ifdef FFT_IDX_SCHED_STATUS_EN
        check("t2_lvl0", lvl0, 6'd32);
        check("t2_ovf", ovf_err, 1'b1);
`endif
        for (int k = 0; k < 32; k++) begin
            bus.idx1_in = vec(31 - k); bus.idx1_valid = 1'b1;
            step();
        end
        bus.idx1_valid = 1'b0;
        bus.data_req = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            check("t2_valid", bus.idx_valid, 1'b1);
            check("t2_out0", bus.idx0_out, vec(k));
            check("t2_out1", bus.idx1_out, vec(31 - k));
            check("t2_fd", bus.frame_done, logic'(k == 31));
        end
        bus.data_req = 1'b0;
        step();
`ifdef FFT_IDX_SCHED_STATUS_EN
        check("t2_lvl0_end", lvl0, 6'd0);
`endif

        // Test 3: underflow with FIFO1 empty, then a same-cycle push must not bypass
        bus.idx0_in = vec(7); bus.idx0_valid = 1'b1;
        step();
        bus.idx0_valid = 1'b0;
        bus.data_req = 1'b1;
        step();
        check("t3_valid", bus.idx_valid, 1'b0);
        check("t3_out0", bus.idx0_out, '0);
        check("t3_out1", bus.idx1_out, '0);
        check("t3_fs", bus.frame_start, 1'b0);
`ifdef FFT_IDX_SCHED_STATUS_EN
        check("t3_udf", udf_err, 1'b1);
        check("t3_lvl0", lvl0, 6'd1);
`endif
        bus.idx1_in = vec(12); bus.idx1_valid = 1'b1;
        step();
        bus.idx1_valid = 1'b0;
        check("t3_nobypass", bus.idx_valid, 1'b0);
        step();
        check("t3_pop_valid", bus.idx_valid, 1'b1);
        check("t3_pop_out0", bus.idx0_out, vec(7));
        check("t3_pop_out1", bus.idx1_out, vec(12));
        check("t3_pop_fs", bus.frame_start, 1'b1);
        check("t3_pop_busy", bus.busy, 1'b1);
        bus.data_req = 1'b0;

        // Test 5: reach block 10 of a frame, then reset mid-frame
        for (int k = 0; k < 9; k++) begin
            bus.idx0_in = vec(k + 1); bus.idx1_in = vec(k + 1);
            bus.idx0_valid = 1'b1; bus.idx1_valid = 1'b1;
            step();
        end
        bus.idx0_valid = 1'b0; bus.idx1_valid = 1'b0;
        bus.data_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            check("t5_out0", bus.idx0_out, vec(k + 1));
        end
        bus.data_req = 1'b0;
        check("t5_busy_mid", bus.busy, 1'b1);
        check("t5_fd_mid", bus.frame_done, 1'b0);
`ifdef FFT_IDX_SCHED_STATUS_EN
        check("t5_blk", blk_cnt_o, 6'd10);
`endif
        rstn = 1'b0;
        step();
        check("t5_rst_valid", bus.idx_valid, 1'b0);
        check("t5_rst_out0", bus.idx0_out, '0);
        check("t5_rst_out1", bus.idx1_out, '0);
        check("t5_rst_busy", bus.busy, 1'b0);
`ifdef FFT_IDX_SCHED_STATUS_EN
        check("t5_rst_lvl0", lvl0, 6'd0);
        check("t5_rst_ovf", ovf_err, 1'b0);
        check("t5_rst_udf", udf_err, 1'b0);
`endif
        rstn = 1'b1;
        step();

        // Test 4 + 6: full FIFOs, push+pop together, then two back-to-back frames
        for (int k = 0; k < 32; k++) begin
            bus.idx0_in = vec(k); bus.idx1_in = vec(31 - k);
            bus.idx0_valid = 1'b1; bus.idx1_valid = 1'b1;
            q0.push_back(vec(k)); q1.push_back(vec(31 - k));
            step();
        end
        bus.data_req = 1'b1;
        for (int j = 0; j < 64; j++) begin
            bus.idx0_in = vec((j * 3 + 9) % 32);
            bus.idx1_in = vec((j * 5 + 2) % 32);
            step();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            q0.push_back(vec((j * 3 + 9) % 32));
            q1.push_back(vec((j * 5 + 2) % 32));
            check("t6_valid", bus.idx_valid, 1'b1);
            check("t6_out0", bus.idx0_out, e0);
            check("t6_out1", bus.idx1_out, e1);
            check("t6_fs", bus.frame_start, logic'((j % 32) == 0));
            check("t6_fd", bus.frame_done, logic'((j % 32) == 31));
            check("t6_busy", bus.busy, logic'((j % 32) != 31));
`ifdef FFT_IDX_SCHED_STATUS_EN
            check("t4_lvl0", lvl0, 6'd32);
            check("t4_lvl1", lvl1, 6'd32);
            check("t4_ovf", ovf_err, 1'b0);
`endif
        end
        bus.data_req = 1'b0;
        bus.idx0_valid = 1'b0; bus.idx1_valid = 1'b0;
        step();
        check("end_valid", bus.idx_valid, 1'b0);
        check("end_busy", bus.busy, 1'b0);
        check("end_hold", bus.idx0_out, e0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
